// File: rtl/cf_share_compress.sv
// ---------------------------------------------------------------------------
// cf_share_compress
//
// Two-stage share compression for a masked component-function datapath.
// Stage 1 captures the 27 expanded shares exactly as presented, with no
// logic in front of the flops, so glitches from upstream cannot combine
// shares before they are registered. Stage 2 folds each triplet of stage-1
// bits into one output share. Both stages use a valid/ready handshake, so
// the pipeline holds up to two items and streams one item per cycle.
//
// Ports
//   clk         clock, rising edge
//   rst         asynchronous reset, active high
//   in_valid    upstream offers in_shares
//   in_ready    block accepts in_shares this cycle
//   in_shares   27 expanded shares; bit n = instance n, coordinate n/9
//   out_valid   out_shares holds a compressed result
//   out_ready   downstream consumes out_shares this cycle
//   out_shares  bit 3k+j = share j of coordinate k
//   xfer_cnt    completed output transfers, saturating at 16'hFFFF
//   unmasked    (only with CF_SHARE_COMPRESS_UNMASK_EN) bit k = XOR of
//               the three shares of coordinate k; debug use only
//
// Build option
//   CF_SHARE_COMPRESS_UNMASK_EN  adds the unmasked debug port and its
//                                register; undefined = no unmasking logic.
// ---------------------------------------------------------------------------
module cf_share_compress (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [26:0] in_shares,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [8:0]  out_shares,
  output logic [15:0] xfer_cnt
`ifdef CF_SHARE_COMPRESS_UNMASK_EN
  ,
  output logic [2:0]  unmasked
`endif
);

  logic        s1_valid_q, s1_valid_d;
  logic [26:0] s1_data_q,  s1_data_d;
  logic        s2_valid_q, s2_valid_d;
  logic [8:0]  s2_data_q,  s2_data_d;
  logic [15:0] cnt_q,      cnt_d;

  logic        in_xfer;
  logic        out_xfer;
  logic        s1_move;
  logic [8:0]  fold;

  // Triplet fold: output share 3k+j combines stage-1 bits 9k+3j .. 9k+3j+2.
  // Only registered stage-1 bits feed this, never in_shares directly.
  for (genvar g = 0; g < 9; g++) begin : g_fold
    assign fold[g] = s1_data_q[3*g] ^ s1_data_q[3*g+1] ^ s1_data_q[3*g+2];
  end

  assign out_xfer = s2_valid_q & out_ready;
  // Stage 1 advances when it holds an item and stage 2 is free or draining.
  assign s1_move  = s1_valid_q & (~s2_valid_q | out_xfer);
  // No dependency on in_valid; out_ready may reach in_ready combinationally.
  assign in_ready = ~s1_valid_q | s1_move;
  assign in_xfer  = in_valid & in_ready;

  always_comb begin
    s1_valid_d = s1_valid_q;
    s1_data_d  = s1_data_q;
    s2_valid_d = s2_valid_q;
    s2_data_d  = s2_data_q;
    cnt_d      = cnt_q;

    if (in_xfer) begin
      s1_valid_d = 1'b1;
      s1_data_d  = in_shares;
    end else if (s1_move) begin
      s1_valid_d = 1'b0;
    end

    if (s1_move) begin
      s2_valid_d = 1'b1;
      s2_data_d  = fold;
    end else if (out_xfer) begin
      s2_valid_d = 1'b0;
    end

    if (out_xfer && (cnt_q != 16'hFFFF)) begin
      cnt_d = cnt_q + 16'd1;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      s1_valid_q <= 1'b0;
      s1_data_q  <= '0;
      s2_valid_q <= 1'b0;
      s2_data_q  <= '0;
      cnt_q      <= '0;
    end else begin
      s1_valid_q <= s1_valid_d;
      s1_data_q  <= s1_data_d;
      s2_valid_q <= s2_valid_d;
      s2_data_q  <= s2_data_d;
      cnt_q      <= cnt_d;
    end
  end

  assign out_valid  = s2_valid_q;
  assign out_shares = s2_data_q;
  assign xfer_cnt   = cnt_q;

`ifdef CF_SHARE_COMPRESS_UNMASK_EN
  logic [2:0] unmask_q, unmask_d;

  // Loaded alongside stage 2 so it always matches the shares on out_shares.
  always_comb begin
    unmask_d = unmask_q;
    if (s1_move) begin
      for (int k = 0; k < 3; k++) begin
        unmask_d[k] = ^fold[3*k +: 3];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      unmask_q <= '0;
    end else begin
      unmask_q <= unmask_d;
    end
  end

  assign unmasked = unmask_q;
`endif

endmodule

// File: tb/tb_cf_share_compress.sv
module tb_cf_share_compress;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [26:0] in_shares = '0;
  logic        out_valid;
  logic        out_ready = 1'b0;
  logic [8:0]  out_shares;
  logic [15:0] xfer_cnt;
`ifdef CF_SHARE_COMPRESS_UNMASK_EN
  logic [2:0]  unmasked;
`endif

  int checks = 0;
  int failures = 0;
  logic [8:0] exp_q[$];

  always #5 clk = ~clk;

  cf_share_compress dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_shares  (in_shares),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_shares (out_shares),
    .xfer_cnt   (xfer_cnt)
`ifdef CF_SHARE_COMPRESS_UNMASK_EN
    ,
    .unmasked   (unmasked)
`endif
  );

  // Reference: instance n belongs to coordinate n/9, share (n%9)/3, so it
  // lands in output bit 3*(n/9) + (n%9)/3 == n/3.
  function automatic logic [8:0] compress(input logic [26:0] x);
    logic [8:0] r;
    r = '0;
    for (int n = 0; n < 27; n++) r[n/3] = r[n/3] ^ x[n];
    return r;
  endfunction

  // Advances one clock; reports the handshakes seen before the edge.
  task automatic tick(output logic ifire, output logic ofire, output logic [8:0] odata);
    @(negedge clk);
    ifire = in_valid && in_ready;
    ofire = out_valid && out_ready;
    odata = out_shares;
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
  endtask

  task automatic test_reset();
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL reset_out_valid got=%b want=0", out_valid); end
    checks++; if (out_shares !== 9'h000) begin failures++; $display("FAIL reset_out_shares got=%h want=000", out_shares); end
    checks++; if (xfer_cnt !== 16'h0000) begin failures++; $display("FAIL reset_xfer_cnt got=%h want=0000", xfer_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_during got=%b want=1", in_ready); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    #1;
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready_after got=%b want=1", in_ready); end
  endtask

  task automatic test_single(input logic [26:0] din, input logic [8:0] want, input logic [15:0] want_cnt);
    logic ifire, ofire;
    logic [8:0] od;
    out_ready = 1'b1;
    in_valid  = 1'b1;
    in_shares = din;
    tick(ifire, ofire, od);
    in_valid = 1'b0;
    checks++; if (ifire !== 1'b1) begin failures++; $display("FAIL single_accept got=%b want=1", ifire); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_t1_valid got=%b want=0", out_valid); end
    tick(ifire, ofire, od);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL single_t2_valid got=%b want=1", out_valid); end
    checks++; if (out_shares !== want) begin failures++; $display("FAIL single_data got=%h want=%h", out_shares, want); end
`ifdef CF_SHARE_COMPRESS_UNMASK_EN
    checks++;
    if (unmasked !== {^want[8:6], ^want[5:3], ^want[2:0]}) begin
      failures++; $display("FAIL single_unmasked got=%b want=%b", unmasked, {^want[8:6], ^want[5:3], ^want[2:0]});
    end
`endif
    tick(ifire, ofire, od);
    checks++; if (ofire !== 1'b1) begin failures++; $display("FAIL single_consumed got=%b want=1", ofire); end
    checks++; if (xfer_cnt !== want_cnt) begin failures++; $display("FAIL single_xfer_cnt got=%0d want=%0d", xfer_cnt, want_cnt); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL single_drained got=%b want=0", out_valid); end
  endtask

  task automatic test_backpressure();
    logic ifire, ofire;
    logic [8:0] od, e;
    logic [26:0] d[3];
    int idx, got;
    do_reset();
    for (int i = 0; i < 3; i++) d[i] = 27'($urandom);
    out_ready = 1'b0;
    idx = 0;
    got = 0;
    in_valid  = 1'b1;
    in_shares = d[0];
    for (int c = 0; c < 3; c++) begin
      #1;
      checks++;
      if (in_ready !== ((exp_q.size() < 2) || out_ready)) begin
        failures++; $display("FAIL bp_in_ready cyc=%0d got=%b want=%b", c, in_ready, (exp_q.size() < 2));
      end
      tick(ifire, ofire, od);
      if (ifire) begin
        exp_q.push_back(compress(d[idx]));
        idx++;
        if (idx < 3) in_shares = d[idx];
      end
    end
    checks++; if (idx !== 2) begin failures++; $display("FAIL bp_accepted got=%0d want=2", idx); end
    for (int c = 0; c < 2; c++) begin
      checks++; if (in_ready !== 1'b0) begin failures++; $display("FAIL bp_full_in_ready got=%b want=0", in_ready); end
      checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL bp_hold_valid got=%b want=1", out_valid); end
      checks++; if (out_shares !== compress(d[0])) begin failures++; $display("FAIL bp_hold_data got=%h want=%h", out_shares, compress(d[0])); end
      tick(ifire, ofire, od);
    end
    out_ready = 1'b1;
    for (int c = 0; c < 10 && got < 3; c++) begin
      in_valid = (idx < 3);
      tick(ifire, ofire, od);
      if (ifire) begin
        exp_q.push_back(compress(d[idx]));
        idx++;
        if (idx < 3) in_shares = d[idx];
      end
      if (ofire) begin
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL bp_extra_output got=%h want=none", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e) begin failures++; $display("FAIL bp_order item=%0d got=%h want=%h", got, od, e); end
        end
      end
    end
    in_valid = 1'b0;
    checks++; if (got !== 3) begin failures++; $display("FAIL bp_output_count got=%0d want=3", got); end
    checks++; if (xfer_cnt !== 16'd3) begin failures++; $display("FAIL bp_xfer_cnt got=%0d want=3", xfer_cnt); end
  endtask

  task automatic test_stream();
    logic ifire, ofire;
    logic [8:0] od, e;
    logic [26:0] cur;
    int sent, got, first, last, cyc;
    do_reset();
    out_ready = 1'b1;
    sent = 0; got = 0; first = -1; last = -1; cyc = 0;
    in_shares = 27'($urandom);
    while (got < 100 && cyc < 300) begin
      in_valid = (sent < 100);
      cur = in_shares;
      tick(ifire, ofire, od);
      if (sent < 100) begin
        checks++; if (ifire !== 1'b1) begin failures++; $display("FAIL stream_accept cyc=%0d got=%b want=1", cyc, ifire); end
      end
      if (ifire) begin
        exp_q.push_back(compress(cur));
        sent++;
        in_shares = 27'($urandom);
      end
      if (ofire) begin
        if (first < 0) first = cyc;
        last = cyc;
        got++;
        checks++;
        if (exp_q.size() == 0) begin
          failures++; $display("FAIL stream_extra_output got=%h want=none", od);
        end else begin
          e = exp_q.pop_front();
          if (od !== e) begin failures++; $display("FAIL stream_data item=%0d got=%h want=%h", got, od, e); end
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got !== 100) begin failures++; $display("FAIL stream_timeout got=%0d want=100", got); end
    checks++; if (first !== 2) begin failures++; $display("FAIL stream_first_out got=%0d want=2", first); end
    checks++; if (last !== 101) begin failures++; $display("FAIL stream_last_out got=%0d want=101", last); end
    checks++; if (xfer_cnt !== 16'd100) begin failures++; $display("FAIL stream_xfer_cnt got=%0d want=100", xfer_cnt); end
  endtask

  task automatic test_reset_mid();
    logic ifire, ofire;
    logic [8:0] od;
    logic [26:0] d;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    for (int i = 0; i < 2; i++) begin
      in_shares = 27'($urandom);
      tick(ifire, ofire, od);
    end
    in_valid = 1'b0;
    checks++; if (out_valid !== 1'b1 || in_ready !== 1'b0) begin failures++; $display("FAIL midrst_full got=%b%b want=10", out_valid, in_ready); end
    #2;
    rst = 1'b1;
    #1;
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_out_valid got=%b want=0", out_valid); end
    checks++; if (xfer_cnt !== 16'd0) begin failures++; $display("FAIL midrst_xfer_cnt got=%0d want=0", xfer_cnt); end
    checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL midrst_in_ready got=%b want=1", in_ready); end
    checks++; if (out_shares !== 9'h000) begin failures++; $display("FAIL midrst_out_shares got=%h want=000", out_shares); end
    @(posedge clk);
    #1;
    rst = 1'b0;
    exp_q.delete();
    out_ready = 1'b1;
    for (int c = 0; c < 3; c++) begin
      tick(ifire, ofire, od);
      checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_stale_item cyc=%0d got=%b want=0", c, out_valid); end
    end
    d = 27'($urandom);
    in_valid  = 1'b1;
    in_shares = d;
    tick(ifire, ofire, od);
    in_valid = 1'b0;
    checks++; if (ifire !== 1'b1) begin failures++; $display("FAIL midrst_accept got=%b want=1", ifire); end
    checks++; if (out_valid !== 1'b0) begin failures++; $display("FAIL midrst_t1_valid got=%b want=0", out_valid); end
    tick(ifire, ofire, od);
    checks++; if (out_valid !== 1'b1) begin failures++; $display("FAIL midrst_t2_valid got=%b want=1", out_valid); end
    checks++; if (out_shares !== compress(d)) begin failures++; $display("FAIL midrst_data got=%h want=%h", out_shares, compress(d)); end
    tick(ifire, ofire, od);
  endtask

  task automatic test_saturate();
    logic ifire, ofire;
    logic [8:0] od;
    int sent, got, cyc;
    logic [15:0] want;
    do_reset();
    out_ready = 1'b1;
    sent = 0; got = 0; cyc = 0;
    while (got < 65537 && cyc < 70000) begin
      in_valid  = (sent < 65537);
      in_shares = 27'($urandom);
      tick(ifire, ofire, od);
      if (ifire) sent++;
      if (ofire) begin
        got++;
        want = (got > 65535) ? 16'hFFFF : 16'(got);
        if (got >= 65534) begin
          checks++; if (xfer_cnt !== want) begin failures++; $display("FAIL sat_cnt n=%0d got=%h want=%h", got, xfer_cnt, want); end
        end
      end
      cyc++;
    end
    in_valid = 1'b0;
    checks++; if (got !== 65537) begin failures++; $display("FAIL sat_timeout got=%0d want=65537", got); end
    for (int c = 0; c < 3; c++) tick(ifire, ofire, od);
    checks++; if (xfer_cnt !== 16'hFFFF) begin failures++; $display("FAIL sat_hold got=%h want=ffff", xfer_cnt); end
  endtask

  initial begin
    test_reset();
    test_single(27'h0000007, 9'h001, 16'd1);
    test_single(27'h7FFFFFF, 9'h1FF, 16'd2);
    test_backpressure();
    test_stream();
    test_reset_mid();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
